game_controller: RTL and testbench
==================================

Name: game_controller

Overview:
- Top-level game sequencer for the crane game.
- Accepts a start button and claw-scoring events, and runs the game timer via an internal one-second tick.
- Owns the live score and high score, and gates the claw.
- Feeds time_left and score to the LED display controller.
- Replaces free-running score/timer logic with an IDLE/PLAY/DRAIN/OVER state machine.

Parameters:
- CLK_HZ, 100000000, clock cycles per second; tick period.
- GAME_SECONDS, 60, game length in seconds; must be at least 1.
- OVER_HOLD_SECONDS, 5, seconds the game-over display holds before returning to IDLE; must be at least 1.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start_btn  in  1  debounced, clock-synchronous level; rising edge starts a game.
- score_event  in  1  synchronous level from the claw sensor; each rising edge is one point.
- claw_busy  in  1  high while a claw drop is in progress.
- game_active  out  1  high in PLAY and DRAIN.
- claw_enable  out  1  high only in PLAY; claw may begin a new drop.
- game_over  out  1  high in OVER.
- new_high  out  1  high in OVER when this game set a new high score.
- time_left  out  16  seconds remaining.
- score  out  16  current or last-game score.
- high_score  out  16  best score since reset.

Behaviour:
- All outputs are registered. Reset is async active-high and forces:
  - state IDLE;
  - score=0, high_score=0, time_left=GAME_SECONDS;
  - game_active=0, claw_enable=0, game_over=0, new_high=0;
  - prescaler=0.
- Edge detect: prev_start and prev_score registers reset to 1, so a level already high at reset release does not fire. edge = in & ~prev.
- Tick: prescaler counts 0..CLK_HZ-1 and wraps. tick is a one-cycle pulse when the count equals CLK_HZ-1. The prescaler clears to 0 on every state entry.
- IDLE:
  - time_left=GAME_SECONDS; score holds the last game's value.
  - On start edge: score<=0, time_left<=GAME_SECONDS, go to PLAY. game_active rises 1 cycle after the edge cycle.
  - score edges are ignored.
- PLAY:
  - game_active=1, claw_enable=1.
  - score edge: score<=score+1, saturating at 16'hFFFF.
  - tick: time_left<=time_left-1.
  - tick with time_left==1: time_left<=0; go to DRAIN if claw_busy, else OVER.
  - start edges are ignored.
- DRAIN:
  - game_active=1, claw_enable=0, time_left=0.
  - score edges still count, so the last drop can score.
  - When claw_busy==0, go to OVER on the next cycle. There is no timeout.
- OVER entry cycle:
  - if score>high_score (strict): high_score<=score, new_high<=1; else new_high<=0.
  - game_over=1, game_active=0, claw_enable=0.
- OVER:
  - Counts OVER_HOLD_SECONDS ticks, then goes to IDLE, clearing game_over and new_high.
  - start and score edges are ignored.
- Simultaneous events:
  - score edge in the same cycle as the final PLAY tick: the point counts.
  - claw_busy falls in the same cycle as the final tick: go to OVER.
- Reset mid-operation, any state: immediate return to reset values; high_score is lost.
- Width rules:
  - time_left is 16-bit; GAME_SECONDS must be at most 65535.
  - prescaler width is $clog2(CLK_HZ).

Decomposition:
- Shared package game_pkg:
  - state enum: IDLE=2'd0, PLAY=2'd1, DRAIN=2'd2, OVER=2'd3;
  - SCORE_W=16, SCORE_MAX=16'hFFFF.
- Sub-module second_tick:
  - parameter CLK_HZ; inputs clock, reset, clear; output tick;
  - instantiated once.

Test Plan (CLK_HZ=10, GAME_SECONDS=3, OVER_HOLD_SECONDS=2):
- Reset, then start edge → game_active=1 after 1 cycle; time_left goes 3→2→1→0 at 10-cycle intervals; OVER follows with claw_busy=0; game_over holds 20 cycles, then IDLE with time_left=3.
- 4 score_event pulses during PLAY → score=4; entering OVER, high_score=4 and new_high=1. A second game scoring 4 gives high_score=4 and new_high=0.
- claw_busy=1 at expiry → DRAIN with claw_enable=0 and game_active=1. A score pulse in DRAIN gives score+1. claw_busy drops → OVER next cycle.
- start_btn held high through reset release → no game starts. start pulses during PLAY and OVER → ignored. score pulses in IDLE → score unchanged.
- Force score=16'hFFFF, then a score pulse → stays 16'hFFFF. A score edge in the same cycle as the final tick → counted.
- Assert reset in PLAY with time_left=2 and score=3 → all outputs return to reset values asynchronously, within the same cycle.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the crane game sequencer.
// State encoding, score width and the saturating score increment.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DRAIN = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam int SCORE_W = 16;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 16'hFFFF;

  function automatic logic [SCORE_W-1:0] sat_inc(
    input logic [SCORE_W-1:0] v
  );
    return (v == SCORE_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/game_controller_second_tick.sv
// One-second tick generator: counts 0..CLK_HZ-1, pulses tick on the last count.
// Ports: clock, reset (async high), clear (sync restart), tick (1-cycle pulse).
module second_tick #(
  parameter int CLK_HZ = 100000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/game_controller.sv
// Crane game sequencer: IDLE/PLAY/DRAIN/OVER, timer, score and high score.
// Ports: clock, reset, start_btn, score_event, claw_busy in; status, time and scores out.
module game_controller
  import game_pkg::*;
#(
  parameter int CLK_HZ            = 100000000,
  parameter int GAME_SECONDS      = 60,
  parameter int OVER_HOLD_SECONDS = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_btn,
  input  logic               score_event,
  input  logic               claw_busy,
  output logic               game_active,
  output logic               claw_enable,
  output logic               game_over,
  output logic               new_high,
  output logic [15:0]        time_left,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score
);

  localparam logic [15:0] GS = 16'(GAME_SECONDS);
  localparam int HW = $clog2(OVER_HOLD_SECONDS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(OVER_HOLD_SECONDS - 1);

  state_t state, state_n;
  logic prev_start, prev_score;
  logic start_edge, score_edge;
  logic tick, clear;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [15:0] time_n;
  logic [SCORE_W-1:0] score_n, high_n;
  logic new_high_n;

  assign start_edge = start_btn & ~prev_start;
  assign score_edge = score_event & ~prev_score;
  assign clear = (state_n != state);

  second_tick #(
    .CLK_HZ(CLK_HZ)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .tick (tick)
  );

  always_comb begin
    state_n    = state;
    score_n    = score;
    high_n     = high_score;
    time_n     = time_left;
    new_high_n = new_high;
    hold_n     = hold_cnt;
    unique case (state)
      IDLE: begin
        time_n = GS;
        if (start_edge) begin
          score_n = '0;
          state_n = PLAY;
        end
      end
      PLAY: begin
        if (score_edge) score_n = sat_inc(score);
        if (tick) begin
          if (time_left <= 16'd1) begin
            time_n  = '0;
            state_n = claw_busy ? DRAIN : OVER;
          end else begin
            time_n = time_left - 1'b1;
          end
        end
      end
      DRAIN: begin
        time_n = '0;
        if (score_edge) score_n = sat_inc(score);
        if (!claw_busy) state_n = OVER;
      end
      OVER: begin
        if (tick) begin
          if (hold_cnt == HOLD_LAST) begin
            state_n    = IDLE;
            time_n     = GS;
            new_high_n = 1'b0;
          end else begin
            hold_n = hold_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // Judge the final score, including a point landing on the exit cycle.
    if (state_n == OVER && state != OVER) begin
      hold_n     = '0;
      new_high_n = (score_n > high_score);
      if (score_n > high_score) high_n = score_n;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      prev_start  <= 1'b1;
      prev_score  <= 1'b1;
      hold_cnt    <= '0;
      score       <= '0;
      high_score  <= '0;
      time_left   <= GS;
      new_high    <= 1'b0;
      game_active <= 1'b0;
      claw_enable <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_n;
      prev_start  <= start_btn;
      prev_score  <= score_event;
      hold_cnt    <= hold_n;
      score       <= score_n;
      high_score  <= high_n;
      time_left   <= time_n;
      new_high    <= new_high_n;
      game_active <= (state_n == PLAY) || (state_n == DRAIN);
      claw_enable <= (state_n == PLAY);
      game_over   <= (state_n == OVER);
    end
  end

endmodule

// File: tb/tb_game_controller.sv
// Directed/randomized bench for game_controller with a small score/timer model.
// Small parameters keep each game to a few dozen cycles.
module tb_game_controller;

  localparam int HZ = 10;
  localparam int GS = 3;
  localparam int HS = 2;
  localparam int LAST = GS * HZ - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start_btn = 1'b0;
  logic score_event = 1'b0;
  logic claw_busy = 1'b0;
  logic game_active, claw_enable, game_over, new_high;
  logic [15:0] time_left, score, high_score;

  int n_assert = 0;
  int n_fail = 0;
  int m_score = 0;
  int m_high = 0;

  game_controller #(
    .CLK_HZ(HZ),
    .GAME_SECONDS(GS),
    .OVER_HOLD_SECONDS(HS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start_btn(start_btn),
    .score_event(score_event),
    .claw_busy(claw_busy),
    .game_active(game_active),
    .claw_enable(claw_enable),
    .game_over(game_over),
    .new_high(new_high),
    .time_left(time_left),
    .score(score),
    .high_score(high_score)
  );

  always #5 clock = ~clock;

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_active"}, game_active, 0);
    chk({tag, "_claw"}, claw_enable, 0);
    chk({tag, "_over"}, game_over, 0);
    chk({tag, "_newhi"}, new_high, 0);
    chk({tag, "_time"}, time_left, GS);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_high"}, high_score, 0);
  endtask

  task automatic start_game();
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    m_score = 0;
  endtask

  // n counts clock edges since PLAY entry; a second elapses every HZ edges.
  task automatic play_run(input int npulses, input bit busy_end,
                          input bit final_edge, input int stop_at,
                          input bit do_sat);
    int want, next_at;
    want = (npulses < 0) ? int'($urandom_range(1, 6)) : npulses;
    next_at = int'($urandom_range(1, 3));
    for (int n = 0; n < stop_at; n++) begin
      chk("play_time", time_left, GS - n / HZ);
      chk("play_score", score, m_score);
      chk("play_active", game_active, 1);
      chk("play_claw", claw_enable, 1);
      if (do_sat && n == 5) begin
        force dut.score = 16'hFFFF;
        m_score = 65535;
      end
      if (do_sat && n == 6) release dut.score;
      if (score_event) begin
        score_event = 1'b0;
      end else if (final_edge && n == LAST) begin
        score_event = 1'b1;
        m_score = sat(m_score + 1);
      end else if (do_sat && n == 8) begin
        score_event = 1'b1;
        m_score = sat(m_score + 1);
      end else if (!do_sat && want > 0 && n >= next_at && n < LAST - 2) begin
        score_event = 1'b1;
        m_score = sat(m_score + 1);
        want--;
        next_at = n + int'($urandom_range(2, 4));
      end
      if (n == 15) start_btn = 1'b1;
      if (n == 16) start_btn = 1'b0;
      claw_busy = (n == LAST) ? busy_end : 1'($urandom_range(0, 1));
      step();
    end
  endtask

  task automatic over_run();
    bit exp_new;
    exp_new = (m_score > m_high);
    if (exp_new) m_high = m_score;
    for (int o = 0; o < HS * HZ; o++) begin
      chk("over_flag", game_over, 1);
      chk("over_newhi", new_high, 32'(exp_new));
      chk("over_high", high_score, m_high);
      chk("over_active", game_active, 0);
      chk("over_claw", claw_enable, 0);
      chk("over_score", score, m_score);
      if (o == 3) start_btn = 1'b1;
      if (o == 4) start_btn = 1'b0;
      if (o == 8) score_event = 1'b1;
      if (o == 9) score_event = 1'b0;
      step();
    end
    chk("idle_over", game_over, 0);
    chk("idle_newhi", new_high, 0);
    chk("idle_time", time_left, GS);
    chk("idle_active", game_active, 0);
    score_event = 1'b1;
    step();
    score_event = 1'b0;
    step();
    chk("idle_score_hold", score, m_score);
    chk("idle_high", high_score, m_high);
  endtask

  task automatic end_play(input bit busy_end);
    score_event = 1'b0;
    chk("end_time", time_left, 0);
    chk("end_score", score, m_score);
    if (busy_end) begin
      chk("drain_active", game_active, 1);
      chk("drain_claw", claw_enable, 0);
      chk("drain_over", game_over, 0);
      score_event = 1'b1;
      m_score = sat(m_score + 1);
      step();
      score_event = 1'b0;
      chk("drain_score", score, m_score);
      repeat (3) step();
      chk("drain_hold", game_active, 1);
      chk("drain_hold_over", game_over, 0);
      claw_busy = 1'b0;
      step();
    end
    over_run();
  endtask

  initial begin
    start_btn = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    chk_reset_vals("rst");
    repeat (5) begin
      step();
      chk("held_start", game_active, 0);
    end
    start_btn = 1'b0;
    step();
    chk("held_start_rel", game_active, 0);

    start_game();
    play_run(4, 1'b0, 1'b0, LAST + 1, 1'b0);
    end_play(1'b0);

    start_game();
    play_run(3, 1'b0, 1'b1, LAST + 1, 1'b0);
    end_play(1'b0);

    start_game();
    play_run(-1, 1'b1, 1'b0, LAST + 1, 1'b0);
    end_play(1'b1);

    start_game();
    play_run(0, 1'b0, 1'b0, LAST + 1, 1'b1);
    end_play(1'b0);

    start_game();
    play_run(3, 1'b0, 1'b0, 15, 1'b0);
    chk("pre_rst_time", time_left, 2);
    chk("pre_rst_score", score, 3);
    reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    step();
    reset = 1'b0;
    m_score = 0;
    m_high = 0;
    step();
    chk_reset_vals("postrst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
